// File: rtl/tlul_socket_m1_throttle.sv
// rtl/tlul_socket_m1_throttle.sv - per-host outstanding limiter and quiesce controller for an M:1 TL-UL socket
// Optional: define CALIPTRA_TLUL_THROTTLE_CNT_ERR_EN to enable the sticky counter-consistency error.

package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_socket_m1_throttle
  import tlul_pkg::*;
#(
  parameter int unsigned  M              = 4,
  parameter int unsigned  MaxOutstanding = 2,
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  tl_h2d_t      tl_h_i [M],
  output tl_d2h_t      tl_h_o [M],
  output tl_h2d_t      tl_s_o [M],
  input  tl_d2h_t      tl_s_i [M],
  input  logic         quiesce_req_i,
  output logic         quiesce_ack_o,
  output logic [M-1:0] busy_o,
  output logic         cnt_err_o
);

  typedef enum logic [1:0] {RUN, DRAIN, QUIESCED} state_e;

  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  state_e              state_q, state_d;
  logic [M*CntW-1:0]   cnt_q, cnt_d;
  logic [M-1:0]        allow, acc, rsp, nz_d;
  logic                all_idle_d;
  logic                ack_q;

  // Only a_valid toward the socket is gated; every other field passes through.
  function automatic tl_h2d_t gate_req(input tl_h2d_t t, input logic en);
    tl_h2d_t r;
    r         = t;
    r.a_valid = t.a_valid & en;
    return r;
  endfunction

  // Only a_ready toward the host is gated; the D channel is never touched.
  function automatic tl_d2h_t gate_rsp(input tl_d2h_t t, input logic en);
    tl_d2h_t r;
    r         = t;
    r.a_ready = t.a_ready & en;
    return r;
  endfunction

  for (genvar g = 0; g < M; g++) begin : g_host
    logic [CntW-1:0] cnt;
    logic            inc, dec;

    assign cnt      = cnt_q[g*CntW +: CntW];
    // allow comes from registers only, so a_valid never loops back into a_ready.
    assign allow[g] = (state_q == RUN) && (cnt < MaxCnt);

    assign tl_s_o[g] = gate_req(tl_h_i[g], allow[g]);
    assign tl_h_o[g] = gate_rsp(tl_s_i[g], allow[g]);

    assign acc[g] = tl_h_i[g].a_valid & allow[g] & tl_s_i[g].a_ready;
    assign rsp[g] = tl_s_i[g].d_valid & tl_h_i[g].d_ready;

    // Simultaneous accept and response cancel; both ends saturate.
    assign inc = acc[g] & ~rsp[g] & (cnt != MaxCnt);
    assign dec = rsp[g] & ~acc[g] & (cnt != '0);
    assign cnt_d[g*CntW +: CntW] = inc ? cnt + 1'b1 : (dec ? cnt - 1'b1 : cnt);

    assign nz_d[g]   = (cnt_d[g*CntW +: CntW] != '0);
    assign busy_o[g] = (cnt != '0);

    cnt_max_a: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt <= MaxCnt);
    acc_run_a: assert property (@(posedge clk_i) disable iff (!rst_ni) acc[g] |-> state_q == RUN);
  end

  assign all_idle_d = ~|nz_d;

  // Quiesce FSM next-state: abort in DRAIN takes priority over completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (quiesce_req_i) state_d = DRAIN;
      DRAIN: begin
        if (!quiesce_req_i)  state_d = RUN;
        else if (all_idle_d) state_d = QUIESCED;
      end
      QUIESCED: if (!quiesce_req_i) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // State, counters and acknowledge registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_q == QUIESCED) && quiesce_req_i;
    end
  end

  assign quiesce_ack_o = ack_q;

  ack_idle_a: assert property (@(posedge clk_i) disable iff (!rst_ni) quiesce_ack_o |-> busy_o == '0);

`ifdef CALIPTRA_TLUL_THROTTLE_CNT_ERR_EN
  logic [M-1:0] err_set;
  logic         err_q;

  for (genvar g = 0; g < M; g++) begin : g_err
    assign err_set[g] = (rsp[g] && (cnt_q[g*CntW +: CntW] == '0)) ||
                        (acc[g] && !rsp[g] && (cnt_q[g*CntW +: CntW] == MaxCnt));
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_q | (|err_set);
  end

  assign cnt_err_o = err_q;
`else
  assign cnt_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_tlul_socket_m1_throttle.sv
// tb/tb_tlul_socket_m1_throttle.sv - self-checking bench for tlul_socket_m1_throttle
module tb_tlul_socket_m1_throttle;
  import tlul_pkg::*;

  localparam int M    = 4;
  localparam int MAXO = 2;
`ifdef CALIPTRA_TLUL_THROTTLE_CNT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  tl_h2d_t       h_in  [M];
  tl_d2h_t       h_out [M];
  tl_h2d_t       s_out [M];
  tl_d2h_t       s_in  [M];
  logic          req;
  logic          ack;
  logic [M-1:0]  busy;
  logic          err;
  logic [2*M-1:0] cnt_flat;

  int checks = 0;
  int errors = 0;

  // reference model: outstanding count per host, admission mode (0 admit, 1 draining, 2 quiesced)
  int mcnt [M];
  int mmode;
  bit mack;
  bit merr;

  always #5 clk = ~clk;

  tlul_socket_m1_throttle #(.M(M), .MaxOutstanding(MAXO)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tl_h_i        (h_in),
    .tl_h_o        (h_out),
    .tl_s_o        (s_out),
    .tl_s_i        (s_in),
    .quiesce_req_i (req),
    .quiesce_ack_o (ack),
    .busy_o        (busy),
    .cnt_err_o     (err)
  );

  assign cnt_flat = dut.cnt_q;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_cnt(input int i);
    logic [2*M-1:0] s;
    s = cnt_flat >> (2 * i);
    return {30'd0, s[1:0]};
  endfunction

  function automatic bit model_allow(input int i);
    return (mmode == 0) && (mcnt[i] < MAXO);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < M; i++) mcnt[i] = 0;
    mmode = 0;
    mack  = 1'b0;
    merr  = 1'b0;
  endtask

  task automatic check_outputs();
    logic [M-1:0] exp_busy;
    for (int i = 0; i < M; i++) begin
      chk("a_valid", i, s_out[i].a_valid, h_in[i].a_valid & model_allow(i));
      chk("a_ready", i, h_out[i].a_ready, s_in[i].a_ready & model_allow(i));
      chk("a_address", i, s_out[i].a_address, h_in[i].a_address);
      chk("d_ready", i, s_out[i].d_ready, h_in[i].d_ready);
      chk("d_valid", i, h_out[i].d_valid, s_in[i].d_valid);
      chk("d_data", i, h_out[i].d_data, s_in[i].d_data);
      chk("cnt", i, dut_cnt(i), mcnt[i]);
      exp_busy[i] = (mcnt[i] != 0);
    end
    chk("busy", 0, busy, exp_busy);
    chk("ack", 0, ack, mack);
    chk("cnt_err", 0, err, merr);
  endtask

  task automatic model_step();
    int ncnt [M];
    bit all_zero;
    bit a, r;
    if (!rst_n) begin
      model_reset();
      return;
    end
    all_zero = 1'b1;
    for (int i = 0; i < M; i++) begin
      a = h_in[i].a_valid && model_allow(i) && s_in[i].a_ready;
      r = s_in[i].d_valid && h_in[i].d_ready;
      if (ERR_EN && r && mcnt[i] == 0) merr = 1'b1;
      ncnt[i] = mcnt[i] + int'(a) - int'(r);
      if (ncnt[i] < 0) ncnt[i] = 0;
      if (ncnt[i] > MAXO) ncnt[i] = MAXO;
      if (ncnt[i] != 0) all_zero = 1'b0;
    end
    mack = (mmode == 2) && req;
    case (mmode)
      0: if (req) mmode = 1;
      1: if (!req) mmode = 0; else if (all_zero) mmode = 2;
      default: if (!req) mmode = 0;
    endcase
    for (int i = 0; i < M; i++) mcnt[i] = ncnt[i];
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    for (int i = 0; i < M; i++) begin
      h_in[i]           = '0;
      h_in[i].d_ready   = 1'b1;
      h_in[i].a_opcode  = 3'd4;
      h_in[i].a_address = $urandom;
      s_in[i]           = '0;
      s_in[i].a_ready   = 1'b1;
      s_in[i].d_data    = $urandom;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    set_idle();
    model_reset();
    tick();
    tick();
    chk("rst_busy", 0, busy, 0);
    chk("rst_ack", 0, ack, 0);
    chk("rst_err", 0, err, 0);
    rst_n = 1'b1;
    tick();

    // host0: D stalled, three back-to-back reads
    h_in[0].a_valid = 1'b1;
    tick();
    tick();
    chk("t1_cnt_full", 0, dut_cnt(0), 2);
    chk("t1_third_blocked", 0, h_out[0].a_ready, 0);
    s_in[0].d_valid = 1'b1;
    tick();
    chk("t1_ready_after_rsp", 0, h_out[0].a_ready, 1);
    s_in[0].d_valid = 1'b0;
    tick();
    chk("t1_cnt_after_third", 0, dut_cnt(0), 2);
    h_in[0].a_valid = 1'b0;
    s_in[0].d_valid = 1'b1;
    tick();
    tick();
    s_in[0].d_valid = 1'b0;

    // host1: accept and response in the same cycle
    h_in[1].a_valid = 1'b1;
    tick();
    s_in[1].d_valid = 1'b1;
    tick();
    chk("t2_cnt_same", 1, dut_cnt(1), 1);
    chk("t2_busy", 0, busy, 4'b0010);
    h_in[1].a_valid = 1'b0;
    tick();
    s_in[1].d_valid = 1'b0;

    // quiesce with host0=2 and host2=1 outstanding
    h_in[0].a_valid = 1'b1;
    h_in[2].a_valid = 1'b1;
    tick();
    h_in[2].a_valid = 1'b0;
    tick();
    req = 1'b1;
    tick();
    h_in[3].a_valid = 1'b1;
    for (int i = 0; i < M; i++) chk("t3_drain_ready", i, h_out[i].a_ready, 0);
    chk("t3_drain_valid", 3, s_out[3].a_valid, 0);
    s_in[0].d_valid = 1'b1;
    tick();
    tick();
    s_in[0].d_valid = 1'b0;
    s_in[2].d_valid = 1'b1;
    tick();
    chk("t3_ack_not_yet", 0, ack, 0);
    s_in[2].d_valid = 1'b0;
    tick();
    chk("t3_ack_rise", 0, ack, 1);
    chk("t3_ack_busy", 0, busy, 0);
    tick();
    req = 1'b0;
    tick();
    chk("t3_ack_fall", 0, ack, 0);
    chk("t3_resume_ready", 0, h_out[0].a_ready, 1);
    tick();
    chk("t3_resume_cnt0", 0, dut_cnt(0), 1);
    chk("t3_resume_cnt3", 3, dut_cnt(3), 1);
    h_in[0].a_valid = 1'b0;
    h_in[3].a_valid = 1'b0;
    s_in[0].d_valid = 1'b1;
    tick();
    s_in[0].d_valid = 1'b0;

    // one-cycle quiesce pulse while host3 has one outstanding
    req = 1'b1;
    tick();
    chk("t4_drain_ready", 3, h_out[3].a_ready, 0);
    req = 1'b0;
    tick();
    chk("t4_ack_low", 0, ack, 0);
    h_in[3].a_valid = 1'b1;
    chk("t4_resume_ready", 3, h_out[3].a_ready, 1);
    tick();
    chk("t4_cnt", 3, dut_cnt(3), 2);
    h_in[3].a_valid = 1'b0;
    s_in[3].d_valid = 1'b1;
    tick();
    tick();
    s_in[3].d_valid = 1'b0;

    // quiesce with no traffic: ack after the third edge
    req = 1'b1;
    tick();
    chk("t5_edge1", 0, ack, 0);
    tick();
    chk("t5_edge2", 0, ack, 0);
    tick();
    chk("t5_edge3", 0, ack, 1);
    req = 1'b0;
    tick();
    chk("t5_fall", 0, ack, 0);

    // response on an idle host
    s_in[0].d_valid = 1'b1;
    tick();
    chk("t6_cnt_zero", 0, dut_cnt(0), 0);
    chk("t6_err", 0, err, ERR_EN);
    s_in[0].d_valid = 1'b0;
    tick();
    chk("t6_err_sticky", 0, err, ERR_EN);

    // reset mid-transaction clears counters and the error flag at once
    h_in[1].a_valid = 1'b1;
    tick();
    h_in[1].a_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t7_cnt_cleared", 1, dut_cnt(1), 0);
    chk("t7_busy", 0, busy, 0);
    chk("t7_err", 0, err, 0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < M; i++) begin
        h_in[i].a_valid   = 1'($urandom_range(0, 1));
        h_in[i].d_ready   = ($urandom_range(0, 3) != 0);
        h_in[i].a_address = $urandom;
        h_in[i].a_data    = $urandom;
        s_in[i].a_ready   = ($urandom_range(0, 3) != 0);
        s_in[i].d_valid   = (mcnt[i] > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 31) == 0);
        s_in[i].d_data    = $urandom;
      end
      if ($urandom_range(0, 19) == 0) req = ~req;
      tick();
    end

    req = 1'b0;
    set_idle();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlul_socket_m1_throttle.md
Name: tlul_socket_m1_throttle

Overview:
- Per-host admission controller placed between M TL-UL hosts and the host ports of the M:1 TL-UL socket.
- Counts outstanding transactions per host and blocks new A-channel requests from a host once it reaches its outstanding limit. This bounds how much of the socket's FIFOs and arbiter one host can occupy.
- Provides a quiesce handshake: stops admitting requests from all hosts, waits for all responses, then acknowledges idle (used before reset or clock gating of the downstream device).

Parameters:
- M, 4, number of host ports; 1..15.
- MaxOutstanding, 2, per-host outstanding limit; 1..15.
- CntW, $clog2(MaxOutstanding+1), counter width; derived, not overridable.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- tl_h_i  input  tl_h2d_t[M]  requests from hosts
- tl_h_o  output  tl_d2h_t[M]  responses to hosts
- tl_s_o  output  tl_h2d_t[M]  requests to socket host ports
- tl_s_i  input  tl_d2h_t[M]  responses from socket host ports
- quiesce_req_i  input  1  level request to drain and hold off traffic
- quiesce_ack_o  output  1  high while quiesced (no outstanding, admission blocked)
- busy_o  output  M  bit i high when host i count is nonzero
- cnt_err_o  output  1  sticky counter-consistency error (see Optional Feature)

Interface note (already decided): one clock, clk_i; reset rst_ni is asynchronous and active-low.

Behaviour:
- Datapath is zero latency. All fields pass through unchanged except tl_s_o[i].a_valid and tl_h_o[i].a_ready.
- Gating:
  - allow[i] = (state==RUN) & (cnt[i] < MaxOutstanding).
  - tl_s_o[i].a_valid = tl_h_i[i].a_valid & allow[i].
  - tl_h_o[i].a_ready = tl_s_i[i].a_ready & allow[i].
  - allow[i] depends on registered state only; there is no combinational path from a_valid to allow.
- Accept event: acc[i] = tl_s_o[i].a_valid & tl_s_i[i].a_ready.
- Response event: rsp[i] = tl_s_i[i].d_valid & tl_h_i[i].d_ready. D channel is never gated.
- Counter update for cnt[i]:
  - acc only: +1.
  - rsp only: -1.
  - both in the same cycle: unchanged.
  - Saturates at 0 and MaxOutstanding; never wraps.
- busy_o[i] = (cnt[i] != 0), registered-derived.
- FSM states: RUN, DRAIN, QUIESCED. Reset state is RUN.
  - RUN -> DRAIN when quiesce_req_i=1.
  - DRAIN -> QUIESCED when quiesce_req_i=1 and all cnt==0 after this cycle's update.
  - DRAIN -> RUN when quiesce_req_i=0, checked before completion.
  - QUIESCED -> RUN when quiesce_req_i=0.
- quiesce_ack_o = (state==QUIESCED), registered. It deasserts the cycle after quiesce_req_i falls.
- In DRAIN and QUIESCED all allow[i]=0. A host with a_valid held sees a_ready=0 and is not accepted.
- If quiesce_req_i is asserted with all counters already zero: RUN -> DRAIN in cycle 1, QUIESCED in cycle 2, ack visible in cycle 3.
- Reset values: all cnt=0, state=RUN, quiesce_ack_o=0, busy_o=0, cnt_err_o=0.
- Reset asserted mid-transaction clears all counters immediately. Responses still in flight after reset are handled by the error rule below.
- Assertions:
  - cnt[i] <= MaxOutstanding at all times.
  - quiesce_ack_o implies busy_o==0.
  - A-channel acceptance never occurs while state != RUN.

Optional Feature:
- Macro: CALIPTRA_TLUL_THROTTLE_CNT_ERR_EN.
- Defined:
  - cnt_err_o is set by a response event on a host with cnt==0 (underflow).
  - cnt_err_o is also set by an accept event with cnt==MaxOutstanding and no response in the same cycle, which is unreachable unless gating is bypassed.
  - Sticky until reset.
- Not defined: cnt_err_o is tied to 0, no error logic is generated, and saturation behaviour is unchanged.

Test Plan:
- M=4, MaxOutstanding=2, device stalls D channel, host0 issues 3 back-to-back reads:
  - first 2 are accepted.
  - the 3rd sees a_ready=0 and cnt[0]=2.
  - after one response, the 3rd is accepted the following cycle and cnt[0] stays at 2.
- Host1 accept and response in the same cycle with cnt[1]=1 -> cnt[1] stays 1 and busy_o=4'b0010.
- 2 outstanding on host0, 1 on host2, quiesce_req_i=1:
  - all a_ready=0 from the next cycle.
  - quiesce_ack_o rises 1 cycle after the final response.
  - quiesce_req_i=0 -> ack falls next cycle and new requests are accepted.
- quiesce_req_i pulsed for 1 cycle while host3 has 1 outstanding -> DRAIN then RUN, ack never asserted, host3 traffic resumes.
- quiesce_req_i=1 with no traffic -> ack high on the 3rd clock edge after assertion.
- Macro defined: inject d_valid on host0 with cnt[0]=0 -> cnt[0] stays 0 and cnt_err_o=1 until rst_ni low. Macro undefined: same stimulus gives cnt_err_o=0.
